// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port SRAM macro (14-bit word address, 32-bit data,
//   active-low byte write enables, one-cycle synchronous read) between NREQ
//   requesters. One burst command is accepted at a time. The arbiter drives
//   the SRAM address, write enables and write data for the granted burst, and
//   returns read beats or a write response on the granted requester's channels.
//
//   Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority, where the
//   lowest index wins and rr_ptr stays at 0. The default is round-robin.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     command handshake, one bit per requester
//   req_write           1 = write burst, 0 = read burst
//   req_addr            byte start address, 16 bits per requester
//   req_len             beats minus 1, 4 bits per requester
//   wvalid/wready       write beat handshake
//   wdata, wstrb        write data, 32 bits per requester, and byte strobes
//   rvalid/rready       read beat handshake
//   rdata, rlast        shared read data and last flag, qualified by rvalid[g]
//   bvalid/bready       write burst response
//   sram_a/web/di/do    SRAM macro interface (sram_do valid 1 cycle after sram_a)
module sram_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*16-1:0]   req_addr,
    input  logic [NREQ*4-1:0]    req_len,
    input  logic [NREQ-1:0]      wvalid,
    output logic [NREQ-1:0]      wready,
    input  logic [NREQ*32-1:0]   wdata,
    input  logic [NREQ*4-1:0]    wstrb,
    output logic [NREQ-1:0]      rvalid,
    input  logic [NREQ-1:0]      rready,
    output logic [31:0]          rdata,
    output logic                 rlast,
    output logic [NREQ-1:0]      bvalid,
    input  logic [NREQ-1:0]      bready,
    output logic [13:0]          sram_a,
    output logic [3:0]           sram_web,
    output logic [31:0]          sram_di,
    input  logic [31:0]          sram_do
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_nxt;
    logic [PTR_W-1:0] gnt, gnt_nxt;
    logic [13:0]      addr, addr_nxt;
    logic [3:0]       len, len_nxt;
    logic [3:0]       cnt, cnt_nxt;

    logic [PTR_W-1:0] win;
    logic             win_found;
    int               arb_idx;

    // Byte-offset bits of the start address are dropped (word-aligned SRAM).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;

    // Search from rr_ptr upward with wrap-around; the first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        arb_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_found && req_valid[arb_idx]) begin
                win_found = 1'b1;
                win       = PTR_W'(arb_idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        gnt_nxt   = gnt;
        addr_nxt  = addr;
        len_nxt   = len;
        cnt_nxt   = cnt;
        req_ready = '0;
        wready    = '0;
        rvalid    = '0;
        bvalid    = '0;
        rdata     = '0;
        rlast     = 1'b0;
        sram_a    = '0;
        sram_web  = 4'hF;
        sram_di   = '0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready[win] = 1'b1;
                    gnt_nxt  = win;
                    addr_nxt = req_addr[16*int'(win)+2 +: 14];
                    len_nxt  = req_len[4*int'(win) +: 4];
                    cnt_nxt  = '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    rr_nxt = (int'(win) == NREQ-1) ? '0 : win + PTR_W'(1);
`endif
                    if (req_write[win]) begin
                        state_nxt = WRITE;
                    end else begin
                        // Issue the first read address now so data is
                        // available the first cycle in READ.
                        state_nxt = READ;
                        sram_a    = addr_nxt;
                    end
                end
            end
            WRITE: begin
                wready[gnt] = 1'b1;
                sram_a      = addr;
                sram_di     = wdata[32*int'(gnt) +: 32];
                if (wvalid[gnt]) begin
                    sram_web = ~wstrb[4*int'(gnt) +: 4];
                    addr_nxt = addr + 14'd1;
                    cnt_nxt  = cnt + 4'd1;
                    if (cnt == len) state_nxt = RESP;
                end
            end
            RESP: begin
                bvalid[gnt] = 1'b1;
                if (bready[gnt]) state_nxt = IDLE;
            end
            READ: begin
                rvalid[gnt] = 1'b1;
                rdata       = sram_do;
                rlast       = (cnt == len);
                sram_a      = addr;
                // Advance the address in the handshake cycle so the next beat
                // is ready one cycle later; hold it under backpressure so
                // sram_do stays stable.
                if (rready[gnt]) begin
                    if (cnt == len) begin
                        state_nxt = IDLE;
                    end else begin
                        addr_nxt = addr + 14'd1;
                        cnt_nxt  = cnt + 4'd1;
                        sram_a   = addr_nxt;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            addr   <= '0;
            len    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            gnt    <= gnt_nxt;
            addr   <= addr_nxt;
            len    <= len_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter with a bus-level reference model: it tracks
//   the accepted burst, the expected memory contents and the round-robin order,
//   and compares the DUT outputs every falling edge. A small SRAM behavioural
//   model sits on the macro pins.
module tb_sram_arbiter;
    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0, req_write = '0, wvalid = '0, rready = '0, bready = '0;
    logic [N-1:0]     req_ready, wready, rvalid, bvalid;
    logic [N*16-1:0]  req_addr = '0;
    logic [N*4-1:0]   req_len = '0, wstrb = '0;
    logic [N*32-1:0]  wdata = '0;
    logic [31:0]      rdata, sram_di;
    logic [31:0]      sram_do = '0;
    logic             rlast;
    logic [13:0]      sram_a;
    logic [3:0]       sram_web;

    int total = 0;
    int bad   = 0;

    sram_arbiter #(.NREQ(N), .PTR_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .bvalid(bvalid), .bready(bready),
        .sram_a(sram_a), .sram_web(sram_web), .sram_di(sram_di), .sram_do(sram_do)
    );

    always #5 clk = ~clk;

    // SRAM macro: byte writes on active-low enables, registered read.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
        sram_do <= mem[sram_a];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no response, expected one within the cycle budget", nm);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:16383];
    bit          m_busy = 0, m_wr = 0, m_resp = 0;
    int          m_g = 0, m_base = 0, m_len = 0, m_k = 0, m_rr = 0;
    int          glog[$];

    always @(negedge clk) begin
        int          gsel, cur, ea;
        logic [N-1:0] e_rdy, e_wr, e_rv, e_bv;
        logic [3:0]  e_web;
        bit          hs_w, hs_r, last;
        logic [31:0] nd;
        if (!rst_n) begin
            m_busy = 0; m_resp = 0; m_rr = 0;
        end else begin
            gsel = -1;
            if (!m_busy)
                for (int k = 0; k < N; k++)
                    if (gsel < 0 && req_valid[(m_rr + k) % N]) gsel = (m_rr + k) % N;
            e_rdy = (gsel >= 0) ? N'(1) << gsel : '0;
            e_wr  = (m_busy && m_wr && !m_resp) ? N'(1) << m_g : '0;
            e_bv  = m_resp ? N'(1) << m_g : '0;
            e_rv  = (m_busy && !m_wr) ? N'(1) << m_g : '0;
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("wready", 32'(wready), 32'(e_wr));
            chk("bvalid", 32'(bvalid), 32'(e_bv));
            chk("rvalid", 32'(rvalid), 32'(e_rv));
            cur   = (m_base + m_k) % 16384;
            hs_w  = (e_wr != 0) && wvalid[m_g];
            e_web = hs_w ? ~wstrb[4*m_g +: 4] : 4'hF;
            chk("sram_web", 32'(sram_web), 32'(e_web));
            if (hs_w) begin
                chk("write_addr", 32'(sram_a), cur);
                chk("sram_di", sram_di, wdata[32*m_g +: 32]);
            end
            last = 0;
            hs_r = 0;
            if (e_rv != 0) begin
                last = (m_k == m_len);
                hs_r = rready[m_g];
                chk("rdata", rdata, ref_mem[cur]);
                chk("rlast", 32'(rlast), 32'(last));
                if (!(hs_r && last)) begin
                    ea = hs_r ? (cur + 1) % 16384 : cur;
                    chk("read_addr", 32'(sram_a), ea);
                end
            end
            if (gsel >= 0 && !req_write[gsel])
                chk("read_issue", 32'(sram_a), 32'(req_addr[16*gsel+2 +: 14]));
            for (int i = 0; i < N; i++)
                if (req_ready[i] && req_valid[i]) glog.push_back(i);
            // advance the model to the state after the coming rising edge
            if (m_resp) begin
                if (bready[m_g]) begin m_resp = 0; m_busy = 0; end
            end else if (hs_w) begin
                nd = ref_mem[cur];
                for (int b = 0; b < 4; b++)
                    if (wstrb[4*m_g+b]) nd[8*b +: 8] = wdata[32*m_g+8*b +: 8];
                ref_mem[cur] = nd;
                m_k++;
                if (m_k > m_len) m_resp = 1;
            end else if (e_rv != 0 && hs_r) begin
                if (last) m_busy = 0;
                else m_k++;
            end
            if (gsel >= 0) begin
                m_busy = 1;
                m_g    = gsel;
                m_wr   = req_write[gsel];
                m_base = int'(req_addr[16*gsel+2 +: 14]);
                m_len  = int'(req_len[4*gsel +: 4]);
                m_k    = 0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                m_rr   = (gsel + 1) % N;
`endif
            end
        end
    end

    // ---------------- drivers ----------------
    logic [31:0] got_d [0:15];
    bit          got_l [0:15];

    task automatic req_cmd(input int r, input bit wr, input logic [15:0] a, input logic [3:0] l);
        bit ok;
        req_write[r] = wr;
        req_addr[16*r +: 16] = a;
        req_len[4*r +: 4] = l;
        req_valid[r] = 1'b1;
        ok = 0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) timeout("req_ready");
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic do_write(input int r, input logic [15:0] a, input logic [3:0] l, input int nsend,
                            input logic [31:0] d0, input logic [3:0] s,
                            output logic [13:0] cap_a, output logic [3:0] cap_web);
        bit ok;
        cap_a = '0;
        cap_web = 4'hF;
        req_cmd(r, 1'b1, a, l);
        for (int k = 0; k < nsend; k++) begin
            wvalid[r] = 1'b1;
            wdata[32*r +: 32] = d0 + 32'(k);
            wstrb[4*r +: 4] = s;
            ok = 0;
            for (int n = 0; n < 100 && !ok; n++) begin
                @(negedge clk);
                if (wready[r]) ok = 1;
                else begin @(posedge clk); #1; end
            end
            if (!ok) timeout("wready");
            if (k == 0) begin cap_a = sram_a; cap_web = sram_web; end
            @(posedge clk); #1;
        end
        wvalid[r] = 1'b0;
    endtask

    task automatic do_bresp(input int r, output int lat);
        bit ok;
        bready[r] = 1'b1;
        lat = 0;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            lat++;
            if (bvalid[r]) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) timeout("bvalid");
        @(posedge clk); #1;
        bready[r] = 1'b0;
    endtask

    task automatic do_read(input int r, input logic [15:0] a, input logic [3:0] l,
                           input logic [15:0] pat, input int plen, output int nb);
        bit done;
        int p;
        req_cmd(r, 1'b0, a, l);
        nb = 0; done = 0; p = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            rready[r] = (p < plen) ? pat[p] : 1'b1;
            p++;
            @(negedge clk);
            if (rvalid[r] && rready[r]) begin
                if (nb < 16) begin got_d[nb] = rdata; got_l[nb] = rlast; end
                nb++;
                done = rlast;
            end
            @(posedge clk); #1;
        end
        rready[r] = 1'b0;
        if (!done) timeout("rlast");
    endtask

    task automatic rd_loop(input int r, input logic [15:0] base);
        int nb;
        for (int i = 0; i < 3; i++) do_read(r, base + 16'(i * 4), 4'd0, 16'h0, 0, nb);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_wready"},    32'(wready),    32'h0);
        chk({tag, "_rvalid"},    32'(rvalid),    32'h0);
        chk({tag, "_bvalid"},    32'(bvalid),    32'h0);
        chk({tag, "_rlast"},     32'(rlast),     32'h0);
        chk({tag, "_rdata"},     rdata,          32'h0);
        chk({tag, "_sram_a"},    32'(sram_a),    32'h0);
        chk({tag, "_sram_web"},  32'(sram_web),  32'hF);
        chk({tag, "_sram_di"},   sram_di,        32'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test, expected one within the time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [13:0] ca;
        logic [3:0]  cw;
        int          n;
        int          exp_ord [0:5];
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single write then single read
        do_write(0, 16'h0010, 4'd0, 1, 32'hDEADBEEF, 4'hF, ca, cw);
        chk("t1_sram_a", 32'(ca), 32'h004);
        chk("t1_sram_web", 32'(cw), 32'h0);
        do_bresp(0, n);
        chk("t1_b_latency", n, 1);
        do_read(0, 16'h0010, 4'd0, 16'h0, 0, n);
        chk("t1_beats", n, 1);
        chk("t1_rdata", got_d[0], 32'hDEADBEEF);
        chk("t1_rlast", 32'(got_l[0]), 1);

        // burst read with backpressure 1,0,1,1,0,1
        do_read(1, 16'h0100, 4'd3, 16'b101101, 6, n);
        chk("t2_beats", n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_rdata", got_d[i], 32'hC0DE0040 + 32'(i));
            chk("t2_rlast", 32'(got_l[i]), (i == 3) ? 1 : 0);
        end

        // partial strobe over an all-ones word
        do_write(0, 16'h0200, 4'd0, 1, 32'hFFFFFFFF, 4'hF, ca, cw);
        do_bresp(0, n);
        do_write(1, 16'h0200, 4'd0, 1, 32'h11223344, 4'b0101, ca, cw);
        chk("t3_sram_a", 32'(ca), 32'h080);
        chk("t3_sram_web", 32'(cw), 32'hA);
        do_bresp(1, n);
        do_read(1, 16'h0200, 4'd0, 16'h0, 0, n);
        chk("t3_rdata", got_d[0], 32'hFF22FF44);

        // simultaneous requesters, three bursts each
        glog.delete();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 1, 1, 1};
`else
        exp_ord = '{0, 1, 0, 1, 0, 1};
`endif
        fork
            rd_loop(0, 16'h0400);
            rd_loop(1, 16'h0500);
        join
        chk("t4_grants", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("t4_order", glog[i], exp_ord[i]);

        // address wrap
        do_read(0, 16'hFFFC, 4'd1, 16'h0, 0, n);
        chk("t5_beats", n, 2);
        chk("t5_word3fff", got_d[0], 32'hC0DE3FFF);
        chk("t5_word0000", got_d[1], 32'hC0DE0000);
        chk("t5_rlast", 32'(got_l[1]), 1);

        // reset after beat 2 of a 4-beat write
        do_write(0, 16'h0300, 4'd3, 2, 32'hAAAA0000, 4'hF, ca, cw);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midreset");
        @(negedge clk);
        chk("midreset_bvalid", 32'(bvalid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_read(1, 16'h0300, 4'd3, 16'h0, 0, n);
        chk("t6_beats", n, 4);
        chk("t6_beat0", got_d[0], 32'hAAAA0000);
        chk("t6_beat1", got_d[1], 32'hAAAA0001);
        chk("t6_beat2", got_d[2], 32'hC0DE00C2);
        chk("t6_beat3", got_d[3], 32'hC0DE00C3);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port SRAM macro (14-bit word address, 32-bit data, per-byte active-low write enables, one-cycle synchronous read) between NREQ requesters, e.g. the L1 I-cache and the L1 D-cache refill and writeback paths.
- Accepts one burst command at a time and grants round-robin.
- Sequences the SRAM address, write-enable and read-data timing for the granted burst.
- Returns read data, or a write response, on the granted requester's channels.

Parameters:
- NREQ, 2: number of requesters (2..4).
- PTR_W, 1: grant-index width. Must equal clog2(NREQ).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  command valid, one bit per requester
- req_ready  out  NREQ  command accepted
- req_write  in  NREQ  1 = write burst, 0 = read burst
- req_addr  in  NREQ*16  byte start address; requester i uses slice [16i+15:16i]
- req_len  in  NREQ*4  beats minus 1 (0..15)
- wvalid  in  NREQ  write beat valid
- wready  out  NREQ  write beat accepted
- wdata  in  NREQ*32  write data
- wstrb  in  NREQ*4  byte strobes, active-high
- rvalid  out  NREQ  read beat valid
- rready  in  NREQ  read beat accepted
- rdata  out  32  read data, shared, qualified by rvalid[i]
- rlast  out  1  last read beat, qualified by rvalid[i]
- bvalid  out  NREQ  write burst complete
- bready  in  NREQ  write response accepted
- sram_a  out  14  SRAM word address
- sram_web  out  4  SRAM byte write enables, active-low
- sram_di  out  32  SRAM write data
- sram_do  in  32  SRAM read data, valid the cycle after sram_a is presented

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk):
  - state = IDLE; rr_ptr = 0; beat counter = 0.
  - All ready/valid outputs = 0; rlast = 0; rdata = 0.
  - sram_a = 0, sram_web = 4'hF, sram_di = 0.
  - Reset asserted mid-burst abandons the burst with no response; the SRAM sees no further writes.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - Arbitrate among the req_valid bits, searching from rr_ptr upward with wrap-around.
  - Winner g gets a combinational req_ready[g] = 1 in the same cycle. Losers see 0.
  - On acceptance, latch g, word address = req_addr[15:2], len and write.
  - Next state: WRITE if the burst is a write; otherwise READ, with sram_a = the start word address presented this cycle.
  - rr_ptr is set to g+1 mod NREQ on acceptance.
  - With no req_valid asserted, stay in IDLE and hold sram_web = 4'hF.
- WRITE:
  - wready[g] = 1; all other wready bits = 0.
  - sram_a = current word address; sram_di = wdata[g].
  - sram_web = ~wstrb[g] when wvalid[g], else 4'hF.
  - On each beat, address increments by 1 mod 2^14 and the counter increments.
  - After beat len+1, go to RESP. Extra beats beyond len are not accepted.
- RESP: bvalid[g] = 1 until bready[g], then go to IDLE. Latency from the last write beat to bvalid is 1 cycle.
- READ:
  - rvalid[g] = 1 and rdata = sram_do, starting the cycle after the address issue.
  - rlast = 1 when counter == len.
  - On an rvalid&rready handshake that is not last, sram_a = address+1 combinationally, giving 1 beat per cycle at full throughput.
  - Without a handshake, sram_a holds the current address, so sram_do stays stable under backpressure.
  - A handshake on the last beat returns to IDLE; rvalid drops the next cycle.
- Boundary cases:
  - len = 0 gives a single beat.
  - Address 0x3FFF + 1 wraps to 0x0000.
  - Requests arriving during a burst wait. req_valid must be held by the requester until req_ready.
  - The same requester re-requesting immediately loses to any other pending requester (round-robin).
- Only the granted requester's channels are ever active. At most one burst is outstanding.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, lowest index wins; rr_ptr is unused and held at 0.
  - Undefined (default): round-robin as above.

Test Plan:
- Single write, then single read:
  - Stimulus: req0 write addr 0x0010, len 0, wdata 0xDEADBEEF, wstrb 4'hF.
  - Required: sram_a = 0x004, sram_web = 4'h0 for 1 cycle, bvalid[0] 1 cycle later.
  - Then req0 read of 0x0010 returns 0xDEADBEEF with rlast = 1.
- Burst read with backpressure:
  - Stimulus: req1 read addr 0x0100, len 3; rready toggled 1,0,1,1,0,1.
  - Required: 4 beats from words 0x040..0x043 in order, rlast only on beat 4, sram_a held during stalls.
- Partial strobe:
  - Stimulus: write wstrb 4'b0101, data 0x11223344 over 0xFFFFFFFF.
  - Required: sram_web = 4'b1010; readback 0xFF22FF44.
- Simultaneous requests:
  - Stimulus: req0 and req1 both valid continuously, 3 bursts each.
  - Required: grant order 0,1,0,1,0,1. With SRAM_ARB_FIXED_PRIO_EN defined, 0,0,0 then 1,1,1.
- Address wrap:
  - Stimulus: read addr 0xFFFC, len 1.
  - Required: words 0x3FFF then 0x0000.
- Reset mid-burst:
  - Stimulus: rst_n low after beat 2 of a len-3 write.
  - Required: all outputs at reset values, no bvalid, sram_web = 4'hF, next request accepted normally.
